voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator_pkg.sv | 24 ++
 rtl/voice_note_table.sv | 51 +++++
 rtl/voice_allocator.sv | 208 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared types for the polyphonic voice allocator.
// VOICE_STEAL_EN selects round-robin stealing when every voice is busy.
package voice_allocator_pkg;

  localparam int DEF_NUM_VOICES = 32;
  localparam int DEF_STEAL_GAP  = 256;

  typedef logic [6:0] NoteNumber_t;
  typedef logic [4:0] VoiceID_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WRITE,
    STEAL_CLR,
    STEAL_WAIT,
    STEAL_SET
  } AllocState_t;

  function automatic logic [3:0] lane_strobe(VoiceID_t v);
    return 4'b0001 << v[4:3];
  endfunction

endpackage

// File: rtl/voice_note_table.sv
// Per-voice active bit and note number storage.
// One scan read port, one write port; active_o shows the pending write.
import voice_allocator_pkg::*;

module voice_note_table #(
  parameter int NUM_VOICES = DEF_NUM_VOICES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  VoiceID_t              rd_idx_i,
  output logic                  rd_active_o,
  output NoteNumber_t           rd_note_o,
  input  logic                  we_i,
  input  VoiceID_t              wr_idx_i,
  input  logic                  wr_active_i,
  input  logic                  wr_note_we_i,
  input  NoteNumber_t           wr_note_i,
  output logic [NUM_VOICES-1:0] active_o
);

  logic [NUM_VOICES-1:0] active_q;
  logic [NUM_VOICES-1:0] active_d;
  NoteNumber_t           note_q [NUM_VOICES];

  always_comb begin
    active_d = active_q;
    if (we_i) begin
      active_d[wr_idx_i] = wr_active_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
      end
    end else begin
      active_q <= active_d;
      if (we_i && wr_note_we_i) begin
        note_q[wr_idx_i] <= wr_note_i;
      end
    end
  end

  assign rd_active_o = active_q[rd_idx_i];
  assign rd_note_o   = note_q[rd_idx_i];
  // Bypass so the vector changes in the same cycle as the strobe.
  assign active_o    = active_d;

endmodule

// File: rtl/voice_allocator.sv
// Note-event voice allocator: full-length scan, then one table write.
// Build with VOICE_STEAL_EN to steal round-robin instead of dropping.
import voice_allocator_pkg::*;

module voice_allocator #(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int STEAL_GAP  = DEF_STEAL_GAP
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_EventValid,
  output logic                  o_EventReady,
  input  logic                  i_EventNoteOn,
  input  logic [6:0]            i_EventNote,
  output logic [3:0]            o_NoteOnConfigWriteEnable,
  output logic [7:0]            o_ConfigWriteData,
  output logic [NUM_VOICES-1:0] o_VoiceActive,
  output logic                  o_AllocValid,
  output logic [4:0]            o_AllocVoice,
  output logic                  o_Dropped
);

  AllocState_t state_q, state_d;
  VoiceID_t    scan_q, scan_d;
  logic        ev_on_q, ev_on_d;
  NoteNumber_t ev_note_q, ev_note_d;
  logic        hit_found_q, hit_found_d;
  VoiceID_t    hit_q, hit_d;
  logic        free_found_q, free_found_d;
  VoiceID_t    free_q, free_d;

`ifdef VOICE_STEAL_EN
  localparam int GW = $clog2(STEAL_GAP + 1);
  logic [GW-1:0] gap_q, gap_d;
  VoiceID_t      steal_q, steal_d;
`endif

  logic        rd_active;
  NoteNumber_t rd_note;
  logic        tbl_we;
  VoiceID_t    tbl_idx;
  logic        tbl_act;
  logic        tbl_note_we;
  logic [31:0] act_pad;

  voice_note_table #(
    .NUM_VOICES(NUM_VOICES)
  ) u_table (
    .clk_i       (i_Clock),
    .rst_i       (i_Reset),
    .rd_idx_i    (scan_q),
    .rd_active_o (rd_active),
    .rd_note_o   (rd_note),
    .we_i        (tbl_we),
    .wr_idx_i    (tbl_idx),
    .wr_active_i (tbl_act),
    .wr_note_we_i(tbl_note_we),
    .wr_note_i   (ev_note_q),
    .active_o    (o_VoiceActive)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      scan_q       <= '0;
      ev_on_q      <= 1'b0;
      ev_note_q    <= '0;
      hit_found_q  <= 1'b0;
      hit_q        <= '0;
      free_found_q <= 1'b0;
      free_q       <= '0;
`ifdef VOICE_STEAL_EN
      gap_q        <= '0;
      steal_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      ev_on_q      <= ev_on_d;
      ev_note_q    <= ev_note_d;
      hit_found_q  <= hit_found_d;
      hit_q        <= hit_d;
      free_found_q <= free_found_d;
      free_q       <= free_d;
`ifdef VOICE_STEAL_EN
      gap_q        <= gap_d;
      steal_q      <= steal_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    ev_on_d      = ev_on_q;
    ev_note_d    = ev_note_q;
    hit_found_d  = hit_found_q;
    hit_d        = hit_q;
    free_found_d = free_found_q;
    free_d       = free_q;
`ifdef VOICE_STEAL_EN
    gap_d        = gap_q;
    steal_d      = steal_q;
`endif
    tbl_we       = 1'b0;
    tbl_idx      = '0;
    tbl_act      = 1'b0;
    tbl_note_we  = 1'b0;
    o_AllocValid = 1'b0;
    o_AllocVoice = '0;
    o_Dropped    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_EventValid) begin
          ev_on_d      = i_EventNoteOn;
          ev_note_d    = i_EventNote;
          hit_found_d  = 1'b0;
          free_found_d = 1'b0;
          scan_d       = '0;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        // Lowest index wins, so only the first hit of each kind is kept.
        if (rd_active && rd_note == ev_note_q && !hit_found_q) begin
          hit_found_d = 1'b1;
          hit_d       = scan_q;
        end
        if (!rd_active && !free_found_q) begin
          free_found_d = 1'b1;
          free_d       = scan_q;
        end
        if (scan_q == VoiceID_t'(NUM_VOICES - 1)) begin
          state_d = WRITE;
        end else begin
          scan_d = scan_q + 5'd1;
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (ev_on_q) begin
          if (hit_found_q) begin
            state_d = IDLE;
          end else if (free_found_q) begin
            tbl_we       = 1'b1;
            tbl_idx      = free_q;
            tbl_act      = 1'b1;
            tbl_note_we  = 1'b1;
            o_AllocValid = 1'b1;
            o_AllocVoice = free_q;
          end else begin
`ifdef VOICE_STEAL_EN
            state_d = STEAL_CLR;
`else
            o_Dropped = 1'b1;
`endif
          end
        end else if (hit_found_q) begin
          tbl_we  = 1'b1;
          tbl_idx = hit_q;
        end
      end
`ifdef VOICE_STEAL_EN
      STEAL_CLR: begin
        tbl_we  = 1'b1;
        tbl_idx = steal_q;
        gap_d   = '0;
        state_d = STEAL_WAIT;
      end
      STEAL_WAIT: begin
        // Gives the envelope stage time to see the release.
        if (gap_q == GW'(STEAL_GAP - 1)) begin
          state_d = STEAL_SET;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      STEAL_SET: begin
        tbl_we       = 1'b1;
        tbl_idx      = steal_q;
        tbl_act      = 1'b1;
        tbl_note_we  = 1'b1;
        o_AllocValid = 1'b1;
        o_AllocVoice = steal_q;
        if (steal_q == VoiceID_t'(NUM_VOICES - 1)) begin
          steal_d = '0;
        end else begin
          steal_d = steal_q + 5'd1;
        end
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    act_pad = '0;
    act_pad[NUM_VOICES-1:0] = o_VoiceActive;
  end

  assign o_EventReady = (state_q == IDLE) && !i_Reset;
  assign o_NoteOnConfigWriteEnable = tbl_we ? lane_strobe(tbl_idx) : 4'b0000;
  assign o_ConfigWriteData = tbl_we ? act_pad[{tbl_idx[4:3], 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator against an array-based model.
// Honours VOICE_STEAL_EN in the same way as the design.
module tb_voice_allocator;

  localparam int NV  = 32;
  localparam int GAP = 4;
`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_EventValid = 1'b0;
  logic          o_EventReady;
  logic          i_EventNoteOn = 1'b0;
  logic [6:0]    i_EventNote = '0;
  logic [3:0]    o_NoteOnConfigWriteEnable;
  logic [7:0]    o_ConfigWriteData;
  logic [NV-1:0] o_VoiceActive;
  logic          o_AllocValid;
  logic [4:0]    o_AllocVoice;
  logic          o_Dropped;

  voice_allocator #(
    .NUM_VOICES(NV),
    .STEAL_GAP (GAP)
  ) dut (
    .i_Clock                  (clk),
    .i_Reset                  (i_Reset),
    .i_EventValid             (i_EventValid),
    .o_EventReady             (o_EventReady),
    .i_EventNoteOn            (i_EventNoteOn),
    .i_EventNote              (i_EventNote),
    .o_NoteOnConfigWriteEnable(o_NoteOnConfigWriteEnable),
    .o_ConfigWriteData        (o_ConfigWriteData),
    .o_VoiceActive            (o_VoiceActive),
    .o_AllocValid             (o_AllocValid),
    .o_AllocVoice             (o_AllocVoice),
    .o_Dropped                (o_Dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit m_act [NV];
  int m_note[NV];
  int m_ptr;

  logic       e_rdy;
  logic [3:0] e_strb;
  logic [7:0] e_data;
  logic       e_av;
  logic [4:0] e_id;
  logic       e_dr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mvec();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NV; i++) r[i] = m_act[i];
    return r;
  endfunction

  function automatic logic [63:0] obs_now();
    return {12'h0, o_EventReady, o_NoteOnConfigWriteEnable,
            o_ConfigWriteData, o_AllocValid, o_AllocVoice,
            o_Dropped, 32'(o_VoiceActive)};
  endfunction

  function automatic logic [63:0] exp_now();
    return {12'h0, e_rdy, e_strb, e_data, e_av, e_id, e_dr, mvec()};
  endfunction

  task automatic mclear();
    for (int i = 0; i < NV; i++) begin
      m_act[i]  = 1'b0;
      m_note[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic mwrite(input int v, input bit val);
    logic [31:0] t;
    m_act[v] = val;
    t = mvec();
    e_strb = 4'b0001 << (v / 8);
    e_data = t[(v / 8) * 8 +: 8];
  endtask

  task automatic idle_exp();
    e_rdy = 1'b1; e_strb = '0; e_data = '0;
    e_av = 1'b0; e_id = '0; e_dr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_Reset = 1'b1;
    #1;
    mclear();
    idle_exp();
    e_rdy = 1'b0;
    chk("rst_hold", obs_now(), exp_now());
    @(negedge clk);
    i_Reset = 1'b0;
    #1;
    idle_exp();
    chk("rst_release", obs_now(), exp_now());
  endtask

  task automatic accept(input bit on, input int note);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_EventReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {63'h0, o_EventReady}, 64'h1);
    i_EventValid  = 1'b1;
    i_EventNoteOn = on;
    i_EventNote   = 7'(note);
    @(posedge clk);
    #1;
    i_EventValid = 1'b0;
  endtask

  task automatic run_event(input bit on, input int note);
    int  dup, fr, last;
    bit  stl;
    dup = -1;
    fr  = -1;
    for (int i = 0; i < NV; i++) begin
      if (m_act[i] && m_note[i] == note && dup < 0) dup = i;
      if (!m_act[i] && fr < 0) fr = i;
    end
    stl  = on && dup < 0 && fr < 0 && STEAL;
    last = stl ? NV + 4 + GAP : NV + 2;
    accept(on, note);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      idle_exp();
      e_rdy = (c == last);
      if (c == NV + 1) begin
        if (on) begin
          if (dup >= 0) begin
            e_av = 1'b0;
          end else if (fr >= 0) begin
            mwrite(fr, 1'b1);
            m_note[fr] = note;
            e_av = 1'b1;
            e_id = 5'(fr);
          end else if (!stl) begin
            e_dr = 1'b1;
          end
        end else if (dup >= 0) begin
          mwrite(dup, 1'b0);
        end
      end
      if (stl && c == NV + 2) mwrite(m_ptr, 1'b0);
      if (stl && c == NV + 3 + GAP) begin
        mwrite(m_ptr, 1'b1);
        m_note[m_ptr] = note;
        e_av  = 1'b1;
        e_id  = 5'(m_ptr);
        m_ptr = (m_ptr + 1) % NV;
      end
      chk($sformatf("ev%0d_n%0d_c%0d", on, note, c), obs_now(), exp_now());
    end
  endtask

  initial begin
    mclear();
    idle_exp();
    #1;
    e_rdy = 1'b0;
    chk("power_on_rst", obs_now(), exp_now());
    do_reset();

    run_event(1'b1, 60);
    chk("first_alloc_vec", 64'(o_VoiceActive), 64'h1);
    run_event(1'b1, 60);
    chk("dup_vec", 64'(o_VoiceActive), 64'h1);

    for (int n = 61; n <= 68; n++) run_event(1'b1, n);
    run_event(1'b0, 68);
    chk("off_v8_vec", 64'(o_VoiceActive), 64'hFF);
    run_event(1'b0, 120);

    for (int k = 0; k < 30; k++) begin
      run_event(($urandom_range(9, 0) < 6), 40 + $urandom_range(7, 0));
    end

    do_reset();
    for (int n = 10; n < 10 + NV; n++) run_event(1'b1, n);
    chk("full_vec", 64'(o_VoiceActive), 64'hFFFF_FFFF);
    run_event(1'b1, 99);
    chk("after99_vec", 64'(o_VoiceActive), 64'hFFFF_FFFF);
    run_event(1'b1, 100);
    run_event(1'b0, 12);
    run_event(1'b1, 101);

    do_reset();
    run_event(1'b1, 70);
    accept(1'b1, 71);
    repeat (10) @(negedge clk);
    i_Reset = 1'b1;
    #1;
    mclear();
    idle_exp();
    e_rdy = 1'b0;
    chk("midscan_rst", obs_now(), exp_now());
    @(negedge clk);
    i_Reset = 1'b0;
    for (int c = 0; c < NV + 4; c++) begin
      @(negedge clk);
      idle_exp();
      chk($sformatf("post_rst_c%0d", c), obs_now(), exp_now());
    end
    run_event(1'b1, 72);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
